keypad_matrix_scanner: RTL and testbench

- Column-scanning front end for the 3x4 button matrix: column lines on pins 51-53, row lines on pins 54-57.
- Drives one column low at a time and samples the active-low rows.
- Debounces every key independently and emits per-key state plus one-cycle press/release flags.
- Sits directly upstream of the counter management and LED blocks and replaces the free-running column sensor.

---
 rtl/keypad_matrix_scanner.sv | 261 ++++++++++++++++++++++++++
 tb/tb_keypad_matrix_scanner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_scanner
// Description : Column-scanning front end for an N_ROWS x N_COLS button
//               matrix. Drives one column low at a time, samples the
//               active-low rows through a 2-flop synchroniser, debounces
//               every key independently and reports per-key state plus
//               one-cycle press/release pulses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1               system clock
//   rst_n          in   1               asynchronous active-low reset
//   i_rows         in   N_ROWS          raw rows, active-low, async to clk
//   o_cols         out  N_COLS          column drive, active-low one-hot
//   o_key_state    out  N_ROWS*N_COLS   debounced state, 1 = pressed,
//                                       bit k = row*N_COLS + col
//   o_key_down     out  N_ROWS*N_COLS   one-cycle pulse on press
//   o_key_up       out  N_ROWS*N_COLS   one-cycle pulse on release
//   o_key_valid    out  1               pulse when any o_key_down bit is set
//   o_key_code     out  4               index of most recent press (held)
//   o_any_pressed  out  1               OR of o_key_state
// ============================================================================
module keypad_matrix_scanner #(
  parameter int N_COLS         = 3,
  parameter int N_ROWS         = 4,
  parameter int SETTLE_CYCLES  = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_ROWS-1:0]          i_rows,
  output logic [N_COLS-1:0]          o_cols,
  output logic [N_ROWS*N_COLS-1:0]   o_key_state,
  output logic [N_ROWS*N_COLS-1:0]   o_key_down,
  output logic [N_ROWS*N_COLS-1:0]   o_key_up,
  output logic                       o_key_valid,
  output logic [3:0]                 o_key_code,
  output logic                       o_any_pressed
);

  localparam int c_N_KEYS   = N_ROWS * N_COLS;
  localparam int c_COL_W    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  // SETTLE_CYCLES >= 3, so this is at least 2 bits and holds SETTLE_CYCLES-1.
  localparam int c_SETTLE_W = $clog2(SETTLE_CYCLES);

  localparam logic [c_SETTLE_W-1:0] c_SETTLE_LAST = c_SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [c_COL_W-1:0]    c_COL_LAST    = c_COL_W'(N_COLS - 1);
  localparam logic [3:0]            c_DEB_LAST    = 4'(DEBOUNCE_SCANS - 1);
  localparam logic [N_COLS-1:0]     c_COLS_RST    = ~N_COLS'(1);

  // Scan FSM encoding
  localparam logic [1:0] c_ST_DRIVE   = 2'd0;
  localparam logic [1:0] c_ST_SAMPLE  = 2'd1;
  localparam logic [1:0] c_ST_ADVANCE = 2'd2;

  // --------------------------------------------------------------------------
  // Row synchroniser. Flops idle high so a reset never looks like a press.
  // --------------------------------------------------------------------------
  logic [N_ROWS-1:0] r_rows_meta;
  logic [N_ROWS-1:0] r_rows_sync;
  logic [N_ROWS-1:0] w_rows_pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows_meta <= '1;
      r_rows_sync <= '1;
    end else begin
      r_rows_meta <= i_rows;
      r_rows_sync <= r_rows_meta;
    end
  end

  assign w_rows_pressed = ~r_rows_sync;

  // --------------------------------------------------------------------------
  // Scan FSM: state register / next-state / outputs
  // --------------------------------------------------------------------------
  logic [1:0]            r_fsm;
  logic [1:0]            w_fsm_nxt;
  logic [c_SETTLE_W-1:0] r_settle;
  logic                  w_sample_en;
  logic                  w_advance;
  logic                  w_settle_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= c_ST_DRIVE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      c_ST_DRIVE:   if (r_settle == c_SETTLE_LAST) w_fsm_nxt = c_ST_SAMPLE;
      c_ST_SAMPLE:  w_fsm_nxt = c_ST_ADVANCE;
      c_ST_ADVANCE: w_fsm_nxt = c_ST_DRIVE;
      default:      w_fsm_nxt = c_ST_DRIVE;
    endcase
  end

  always_comb begin
    w_sample_en  = (r_fsm == c_ST_SAMPLE);
    w_advance    = (r_fsm == c_ST_ADVANCE);
    w_settle_inc = (r_fsm == c_ST_DRIVE) && (r_settle != c_SETTLE_LAST);
  end

  // Settle counter: runs 0..SETTLE_CYCLES-1 in DRIVE, parks during SAMPLE,
  // clears in ADVANCE so the next column starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
    end else if (w_advance) begin
      r_settle <= '0;
    end else if (w_settle_inc) begin
      r_settle <= r_settle + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Column index and registered one-hot-low drive. The drive is a register
  // rather than a decode of r_col so the pins never glitch on a column change.
  // --------------------------------------------------------------------------
  logic [c_COL_W-1:0] r_col;
  logic [c_COL_W-1:0] w_col_nxt;
  logic [N_COLS-1:0]  w_cols_nxt;
  logic [N_COLS-1:0]  r_cols;

  assign w_col_nxt = (r_col == c_COL_LAST) ? '0 : r_col + 1'b1;

  for (genvar gc = 0; gc < N_COLS; gc++) begin : g_col_drive
    assign w_cols_nxt[gc] = (w_col_nxt != c_COL_W'(gc));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_cols <= c_COLS_RST;
    end else if (w_advance) begin
      r_col  <= w_col_nxt;
      r_cols <= w_cols_nxt;
    end
  end

  assign o_cols = r_cols;

  // --------------------------------------------------------------------------
  // Per-key debouncers. Only keys in the column being sampled can change;
  // all others hold state and count. Pulses are registered at the edge that
  // ends SAMPLE and self-clear one cycle later, so they live in ADVANCE only.
  // --------------------------------------------------------------------------
  logic [c_N_KEYS-1:0] w_state_all;
  logic [c_N_KEYS-1:0] w_state_nxt_all;
  logic [c_N_KEYS-1:0] w_down_all;
  logic [c_N_KEYS-1:0] w_down_nxt_all;
  logic [c_N_KEYS-1:0] w_up_all;

  for (genvar gr = 0; gr < N_ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < N_COLS; gc++) begin : g_key
      localparam int c_K = gr * N_COLS + gc;

      logic [3:0] r_cnt;
      logic       r_state;
      logic       r_down;
      logic       r_up;
      logic [3:0] w_cnt_nxt;
      logic       w_state_nxt;
      logic       w_down_nxt;
      logic       w_up_nxt;
      logic       w_hit;
      logic       w_raw;

      assign w_hit = w_sample_en && (r_col == c_COL_W'(gc));
      assign w_raw = w_rows_pressed[gr];

      always_comb begin
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        w_down_nxt  = 1'b0;
        w_up_nxt    = 1'b0;
        if (w_hit) begin
          if (w_raw == r_state) begin
            // Any agreeing sample restarts the disagreement run.
            w_cnt_nxt = 4'd0;
          end else if (r_cnt == c_DEB_LAST) begin
            w_state_nxt = w_raw;
            w_cnt_nxt   = 4'd0;
            w_down_nxt  = w_raw;
            w_up_nxt    = ~w_raw;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt   <= 4'd0;
          r_state <= 1'b0;
          r_down  <= 1'b0;
          r_up    <= 1'b0;
        end else begin
          r_cnt   <= w_cnt_nxt;
          r_state <= w_state_nxt;
          r_down  <= w_down_nxt;
          r_up    <= w_up_nxt;
        end
      end

      assign w_state_all[c_K]     = r_state;
      assign w_state_nxt_all[c_K] = w_state_nxt;
      assign w_down_all[c_K]      = r_down;
      assign w_down_nxt_all[c_K]  = w_down_nxt;
      assign w_up_all[c_K]        = r_up;
    end
  end

  // --------------------------------------------------------------------------
  // Lowest-index press among simultaneous down events. Built as a chain from
  // the top index downwards so the lowest set bit has the final say.
  // --------------------------------------------------------------------------
  logic [3:0] w_code_chain [c_N_KEYS+1];

  assign w_code_chain[c_N_KEYS] = 4'd0;

  for (genvar gk = 0; gk < c_N_KEYS; gk++) begin : g_code
    assign w_code_chain[gk] = w_down_nxt_all[gk] ? 4'(gk) : w_code_chain[gk+1];
  end

  // --------------------------------------------------------------------------
  // Summary outputs, registered alongside the per-key state.
  // --------------------------------------------------------------------------
  logic       r_key_valid;
  logic [3:0] r_key_code;
  logic       r_any_pressed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_valid   <= 1'b0;
      r_key_code    <= 4'd0;
      r_any_pressed <= 1'b0;
    end else begin
      r_key_valid   <= |w_down_nxt_all;
      r_any_pressed <= |w_state_nxt_all;
      if (|w_down_nxt_all) begin
        r_key_code <= w_code_chain[0];
      end
    end
  end

  assign o_key_state   = w_state_all;
  assign o_key_down    = w_down_all;
  assign o_key_up      = w_up_all;
  assign o_key_valid   = r_key_valid;
  assign o_key_code    = r_key_code;
  assign o_any_pressed = r_any_pressed;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_matrix_scanner
// Description : Self-checking bench for keypad_matrix_scanner. A matrix model
//               turns held keys into row levels; a reference model derives
//               the expected scan schedule and debounced results from cycle
//               arithmetic and pushes press/release events to a scoreboard
//               that a separate monitor drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_matrix_scanner;

  localparam int NC     = 3;
  localparam int NR     = 4;
  localparam int NK     = NR * NC;
  localparam int SETTLE = 4;
  localparam int DEB    = 3;
  localparam int PER    = SETTLE + 2;
  localparam int SCAN   = NC * PER;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   i_rows;
  logic [NC-1:0]   o_cols;
  logic [NK-1:0]   o_key_state;
  logic [NK-1:0]   o_key_down;
  logic [NK-1:0]   o_key_up;
  logic            o_key_valid;
  logic [3:0]      o_key_code;
  logic            o_any_pressed;

  logic [NK-1:0]   keys = '0;
  logic [NR-1:0]   glitch = '0;

  keypad_matrix_scanner #(
    .N_COLS(NC), .N_ROWS(NR), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_rows(i_rows), .o_cols(o_cols),
    .o_key_state(o_key_state), .o_key_down(o_key_down), .o_key_up(o_key_up),
    .o_key_valid(o_key_valid), .o_key_code(o_key_code), .o_any_pressed(o_any_pressed)
  );

  always #5 clk = ~clk;

  // Physical matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    i_rows = '1;
    for (int r = 0; r < NR; r++) begin
      if (glitch[r]) i_rows[r] = 1'b0;
      for (int c = 0; c < NC; c++)
        if (keys[r*NC+c] && !o_cols[c]) i_rows[r] = 1'b0;
    end
  end

  typedef struct {
    int            cyc;
    logic [NK-1:0] dn;
    logic [NK-1:0] up;
  } ev_t;

  ev_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit end_req = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. Cycle n after reset release belongs to column
  // (n/PER)%NC; its sample happens at phase SETTLE and sees the row levels
  // from two cycles earlier. Each key counts a run of disagreeing samples.
  // --------------------------------------------------------------------------
  logic [NK-1:0] m_state;
  int            m_run [NK];
  logic [3:0]    m_code;
  logic [NK-1:0] h1_keys, h2_keys;
  logic [NR-1:0] h1_gl, h2_gl;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("reset_cols", o_cols, 3'b110);
      chk("reset_state", o_key_state, '0);
      chk("reset_pulses", {o_key_down, o_key_up, o_key_valid}, '0);
      chk("reset_code", o_key_code, 4'd0);
      chk("reset_any", o_any_pressed, 1'b0);
      m_state = '0;
      m_code  = 4'd0;
      for (int k = 0; k < NK; k++) m_run[k] = 0;
      h1_keys = '0; h2_keys = '0; h1_gl = '0; h2_gl = '0;
      cyc <= 0;
    end else begin
      int            col;
      logic [NC-1:0] ecols;
      logic [NK-1:0] dn, up;
      col   = (cyc / PER) % NC;
      ecols = '1;
      ecols[col] = 1'b0;
      chk("cols", o_cols, ecols);
      chk("key_state", o_key_state, m_state);
      chk("any_pressed", o_any_pressed, |m_state);
      chk("key_code", o_key_code, m_code);
      if (cyc % PER == SETTLE) begin
        dn = '0; up = '0;
        for (int r = 0; r < NR; r++) begin
          int   k;
          logic raw;
          k   = r * NC + col;
          raw = h2_keys[k] | h2_gl[r];
          if (raw == m_state[k]) m_run[k] = 0;
          else begin
            m_run[k]++;
            if (m_run[k] == DEB) begin
              m_state[k] = raw;
              m_run[k]   = 0;
              if (raw) dn[k] = 1'b1; else up[k] = 1'b1;
            end
          end
        end
        for (int k = NK - 1; k >= 0; k--) if (dn[k]) m_code = 4'(k);
        if (|{dn, up}) sb.push_back('{cyc + 1, dn, up});
      end
      h2_keys = h1_keys; h1_keys = keys;
      h2_gl   = h1_gl;   h1_gl   = glitch;
      cyc <= cyc + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: whenever the DUT presents a pulse, pop and compare.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (o_key_valid || (|o_key_down) || (|o_key_up)) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {o_key_down, o_key_up}, '0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("key_down", o_key_down, e.dn);
          chk("key_up", o_key_up, e.up);
          chk("key_valid", o_key_valid, |e.dn);
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        ev_t e;
        e = sb.pop_front();
        chk("missing_event", {o_key_down, o_key_up}, {e.dn, e.up});
      end
      if (end_req) chk("events_pending", sb.size(), 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle scanning
    idle(10 * SCAN);

    // Clean press and release of key 5 (row1, col2)
    keys[5] = 1'b1; idle(5 * SCAN);
    keys[5] = 1'b0; idle(5 * SCAN);

    // Bounce on key 0: 2 scans pressed, 1 released, 3+ pressed
    keys[0] = 1'b1; idle(2 * SCAN);
    keys[0] = 1'b0; idle(SCAN);
    keys[0] = 1'b1; idle(4 * SCAN);
    keys[0] = 1'b0; idle(5 * SCAN);

    // Keys 3 and 4 (different columns), then 3 and 6 (same column)
    keys[3] = 1'b1; keys[4] = 1'b1; idle(5 * SCAN);
    keys = '0; idle(5 * SCAN);
    keys[3] = 1'b1; keys[6] = 1'b1; idle(5 * SCAN);
    keys = '0; idle(5 * SCAN);

    // Reset asserted mid-DRIVE while key 7 is held
    keys[7] = 1'b1; idle(5 * SCAN);
    while (cyc % PER != 1) idle(1);
    rst_n = 1'b0; idle(3);
    rst_n = 1'b1; idle(6 * SCAN);
    keys = '0; idle(5 * SCAN);

    // One-cycle row pulses aligned to the sample cycle, two full scans
    for (int i = 0; i < 2 * NC; i++) begin
      while (cyc % PER != SETTLE) idle(1);
      glitch = 4'b0010; idle(1);
      glitch = 4'b0000; idle(1);
    end
    idle(2 * SCAN);

    // Randomised holds of up to two keys, including short bouncy ones
    for (int i = 0; i < 60; i++) begin
      keys = '0;
      for (int j = 0; j < int'($urandom_range(0, 2)); j++)
        keys[$urandom_range(0, NK - 1)] = 1'b1;
      idle(int'($urandom_range(1, 70)));
    end
    keys = '0;
    idle(6 * SCAN);

    end_req = 1'b1;
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
